logic_gate_unit: RTL

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

---
 rtl/logic_gate_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered bitwise logic unit with ready/valid handshake and optional self-sweep
//
// Purpose:
//   Applies one of eight bitwise operations to operands a and b and presents
//   the result in a single output register (1-cycle latency, 1 result/cycle).
//   With LGU_SWEEP_EN defined, a small FSM can push all 32 op/operand
//   combinations through the same datapath as a self-test sweep.
//
// Configuration macro: LGU_SWEEP_EN (undefined by default -> no sweep logic).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand set present
//   in_ready     out  operand set accepted this cycle
//   a, b         in   operands, WIDTH bits
//   op           in   3-bit operation select
//   out_valid    out  result register occupied
//   out_ready    in   downstream takes the result
//   y            out  registered result, WIDTH bits
//   sweep_start  in   one-cycle sweep request
//   sweep_busy   out  high while sweep vectors are issued
//   sweep_done   out  one-cycle pulse at sweep completion

module logic_gate_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done
);

    function automatic logic [WIDTH-1:0] gate_f(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b
    );
        logic [WIDTH-1:0] r;
        case (f_op)
            3'd0:    r = f_a & f_b;
            3'd1:    r = f_a | f_b;
            3'd2:    r = f_a ^ f_b;
            3'd3:    r = ~(f_a & f_b);
            3'd4:    r = ~(f_a | f_b);
            3'd5:    r = ~(f_a ^ f_b);
            3'd6:    r = ~f_a;
            default: r = f_a;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;

    // Output register can take a new value this cycle (empty or draining).
    logic             out_free;
    logic             load;
    logic [2:0]       ld_op;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] ld_b;

    assign out_free = !out_valid_q || out_ready;

`ifdef LGU_SWEEP_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ld_op    = op;
        ld_a     = a;
        ld_b     = b;
        // sweep_start masks in_ready so a same-cycle request wins over in_valid.
        in_ready = (state_q == ST_IDLE) && !sweep_start && out_free;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = 5'd0;
                end else begin
                    load = in_valid && in_ready;
                end
            end
            ST_SWEEP: begin
                // cnt encodes {op, a-bit, b-bit}; operands are replicated bits.
                if (out_free) begin
                    load  = 1'b1;
                    ld_op = cnt_q[4:2];
                    ld_a  = {WIDTH{cnt_q[1]}};
                    ld_b  = {WIDTH{cnt_q[0]}};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sweep_busy = (state_q == ST_SWEEP);
    assign sweep_done = (state_q == ST_DONE);
`else
    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start;
    assign in_ready           = out_free;
    assign load               = in_valid && out_free;
    assign ld_op              = op;
    assign ld_a               = a;
    assign ld_b               = b;
    assign sweep_busy         = 1'b0;
    assign sweep_done         = 1'b0;
`endif

    // A load always wins over an unload, so simultaneous load+unload keeps
    // out_valid high with the new result (full throughput).
    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (load) begin
            y_d         = gate_f(ld_op, ld_a, ld_b);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule
